// File: rtl/neuron_activation_stage.sv
// neuron_activation_stage: clamped ReLU over a neuron result triple, emitted one element per handshake (optional leaky mode: LEAKY_RELU_EN)
module neuron_activation_stage #(
   parameter int EXP_W       = 5,
   parameter int MAN_W       = 6,
   parameter int MAX_EXP     = 20,
   parameter int LEAKY_SHIFT = 2
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic             SignIn0,
   input  logic             SignIn1,
   input  logic             SignIn2,
   input  logic [EXP_W-1:0] ExponentIn0,
   input  logic [EXP_W-1:0] ExponentIn1,
   input  logic [EXP_W-1:0] ExponentIn2,
   input  logic [MAN_W-1:0] MantissaIn0,
   input  logic [MAN_W-1:0] MantissaIn1,
   input  logic [MAN_W-1:0] MantissaIn2,
   output logic             OutValid,
   input  logic             OutReady,
   output logic             SignOut,
   output logic [EXP_W-1:0] ExponentOut,
   output logic [MAN_W-1:0] MantissaOut,
   output logic [1:0]       OutIndex,
   output logic             OutLast,
   output logic [7:0]       ClampCount
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EMIT0 = 2'd1;
   localparam logic [1:0] EMIT1 = 2'd2;
   localparam logic [1:0] EMIT2 = 2'd3;
   localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_EXP);
   logic [1:0] state;
   logic [W-1:0] hold1, hold2;
   logic [W:0] out_r, nxt;
   function automatic logic [W:0] act(input logic [W-1:0] v);
      logic s;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      {s, e, m} = v;
      if (e == '0 && m == '0) act = '0;
      else if (s) begin
`ifdef LEAKY_RELU_EN
         act = (e <= EXP_W'(LEAKY_SHIFT)) ? '0 : {2'b01, e - EXP_W'(LEAKY_SHIFT), m};
`else
         act = '0;
`endif
      end
      else if (e > MAX_E) act = {2'b10, MAX_E, {MAN_W{1'b1}}};
      else act = {1'b0, v};
   endfunction
   assign InReady  = state == IDLE;
   assign OutValid = state != IDLE;
   assign {SignOut, ExponentOut, MantissaOut} = out_r[W-1:0];
   // activation of the element loaded on the next state entry: input 0 at capture, then held operands
   always_comb begin
      nxt = act(state == IDLE ? {SignIn0, ExponentIn0, MantissaIn0} : state == EMIT0 ? hold1 : hold2);
   end
   // handshake FSM, holding register, registered outputs and saturating clamp counter
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         hold1      <= '0;
         hold2      <= '0;
         out_r      <= '0;
         OutIndex   <= '0;
         OutLast    <= 1'b0;
         ClampCount <= '0;
      end else if (state == IDLE) begin
         if (InValid) begin
            hold1    <= {SignIn1, ExponentIn1, MantissaIn1};
            hold2    <= {SignIn2, ExponentIn2, MantissaIn2};
            out_r    <= nxt;
            OutIndex <= 2'd0;
            OutLast  <= 1'b0;
            state    <= EMIT0;
         end
      end else if (OutReady) begin
         if (out_r[W] && ClampCount != 8'hFF) ClampCount <= ClampCount + 8'd1;
         out_r    <= state == EMIT2 ? out_r : nxt;
         OutIndex <= state == EMIT0 ? 2'd1 : state == EMIT1 ? 2'd2 : OutIndex;
         OutLast  <= OutLast | (state == EMIT1);
         state    <= state == EMIT2 ? IDLE : state + 2'd1;
      end
   end
endmodule

// File: tb/tb_neuron_activation_stage.sv
// tb_neuron_activation_stage: scoreboard bench for neuron_activation_stage (LEAKY_RELU_EN selects leaky expectations)
module tb_neuron_activation_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic s0 = 0, s1 = 0, s2 = 0;
   logic [4:0] e0 = 0, e1 = 0, e2 = 0;
   logic [5:0] m0 = 0, m1 = 0, m2 = 0;
   logic in_ready, out_valid, sign_out, out_last;
   logic [4:0] exp_out;
   logic [5:0] man_out;
   logic [1:0] out_idx;
   logic [7:0] clamp_cnt;
   int total = 0, bad = 0;
   logic [14:0] sb[$];

   neuron_activation_stage dut (
      .Clock(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
      .SignIn0(s0), .SignIn1(s1), .SignIn2(s2),
      .ExponentIn0(e0), .ExponentIn1(e1), .ExponentIn2(e2),
      .MantissaIn0(m0), .MantissaIn1(m1), .MantissaIn2(m2),
      .OutValid(out_valid), .OutReady(out_ready),
      .SignOut(sign_out), .ExponentOut(exp_out), .MantissaOut(man_out),
      .OutIndex(out_idx), .OutLast(out_last), .ClampCount(clamp_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every accepted output is compared with the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) check("unexpected_output", {17'd0, sign_out, exp_out, man_out, out_idx, out_last}, 32'hFFFF_FFFF);
         else check("sb_output", {17'd0, sign_out, exp_out, man_out, out_idx, out_last}, {17'd0, sb.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [11:0] a0, a1, a2, x0, x1, x2);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
      {s0, e0, m0} = a0;
      {s1, e1, m1} = a1;
      {s2, e2, m2} = a2;
      in_valid = 1'b1;
      sb.push_back({x0, 2'd0, 1'b0});
      sb.push_back({x1, 2'd1, 1'b0});
      sb.push_back({x2, 2'd2, 1'b1});
      tick();
      in_valid = 1'b0;
      {s0, e0, m0, s1, e1, m1, s2, e2, m2} = '1;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 50) begin
         tick();
         n++;
      end
      check("drain_timeout", {31'd0, sb.size() == 0 && in_ready}, 32'd1);
   endtask

   initial begin
      repeat (2) tick();
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_fields", {18'd0, sign_out, exp_out, man_out, out_idx, out_last}, 32'd0);
      check("reset_clamp", {24'd0, clamp_cnt}, 32'd0);
      rst = 1'b0;
      tick();
      // basic triple with a negative first element
`ifdef LEAKY_RELU_EN
      send({1'b1, 5'd12, 6'd56}, {1'b0, 5'd12, 6'd7}, {1'b0, 5'd12, 6'd14},
           {1'b1, 5'd10, 6'd56}, {1'b0, 5'd12, 6'd7}, {1'b0, 5'd12, 6'd14});
`else
      send({1'b1, 5'd12, 6'd56}, {1'b0, 5'd12, 6'd7}, {1'b0, 5'd12, 6'd14},
           12'd0, {1'b0, 5'd12, 6'd7}, {1'b0, 5'd12, 6'd14});
`endif
      check("first_valid_latency", {31'd0, out_valid}, 32'd1);
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      repeat (3) tick();
      check("in_ready_after_last", {31'd0, in_ready}, 32'd1);
      check("clamp_after_s1", {24'd0, clamp_cnt}, 32'd0);
      // clamp, exact boundary, and zero
      send({1'b0, 5'd22, 6'd5}, {1'b0, 5'd20, 6'd9}, 12'd0,
           {1'b0, 5'd20, 6'd63}, {1'b0, 5'd20, 6'd9}, 12'd0);
      tick();
      check("clamp_after_first", {24'd0, clamp_cnt}, 32'd1);
      drain();
      check("clamp_after_s2", {24'd0, clamp_cnt}, 32'd1);
      // backpressure in EMIT1
      send({1'b0, 5'd1, 6'd1}, {1'b0, 5'd2, 6'd2}, {1'b0, 5'd3, 6'd3},
           {1'b0, 5'd1, 6'd1}, {1'b0, 5'd2, 6'd2}, {1'b0, 5'd3, 6'd3});
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         {s0, e0, m0} = {1'b0, 5'd9, 6'd9};
         tick();
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_fields", {18'd0, sign_out, exp_out, man_out, out_idx, out_last}, {18'd0, 1'b0, 5'd2, 6'd2, 2'd1, 1'b0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("bp_clamp", {24'd0, clamp_cnt}, 32'd1);
      // reset while in EMIT1
      send({1'b0, 5'd4, 6'd4}, {1'b0, 5'd5, 6'd5}, {1'b0, 5'd6, 6'd6},
           {1'b0, 5'd4, 6'd4}, {1'b0, 5'd5, 6'd5}, {1'b0, 5'd6, 6'd6});
      tick();
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_fields", {18'd0, sign_out, exp_out, man_out, out_idx, out_last}, 32'd0);
      check("mid_rst_clamp", {24'd0, clamp_cnt}, 32'd0);
      out_ready = 1'b1;
      send({1'b0, 5'd7, 6'd1}, {1'b0, 5'd8, 6'd2}, {1'b0, 5'd9, 6'd3},
           {1'b0, 5'd7, 6'd1}, {1'b0, 5'd8, 6'd2}, {1'b0, 5'd9, 6'd3});
      drain();
      // negative inputs, including leaky underflow boundary and negative zero
`ifdef LEAKY_RELU_EN
      send({1'b1, 5'd12, 6'd56}, {1'b1, 5'd2, 6'd40}, {1'b1, 5'd0, 6'd0},
           {1'b1, 5'd10, 6'd56}, 12'd0, 12'd0);
      drain();
      send({1'b1, 5'd3, 6'd5}, {1'b1, 5'd30, 6'd1}, {1'b0, 5'd21, 6'd0},
           {1'b1, 5'd1, 6'd5}, {1'b1, 5'd28, 6'd1}, {1'b0, 5'd20, 6'd63});
`else
      send({1'b1, 5'd12, 6'd56}, {1'b1, 5'd2, 6'd40}, {1'b1, 5'd0, 6'd0},
           12'd0, 12'd0, 12'd0);
      drain();
      send({1'b1, 5'd3, 6'd5}, {1'b1, 5'd30, 6'd1}, {1'b0, 5'd21, 6'd0},
           12'd0, 12'd0, {1'b0, 5'd20, 6'd63});
`endif
      drain();
      check("clamp_after_neg", {24'd0, clamp_cnt}, 32'd1);
      // saturation: 90 triples of clamping values on top of the one clamp above
      for (int t = 0; t < 90; t++) begin
         send({1'b0, 5'd25, 6'd1}, {1'b0, 5'd31, 6'd0}, {1'b0, 5'd21, 6'd63},
              {1'b0, 5'd20, 6'd63}, {1'b0, 5'd20, 6'd63}, {1'b0, 5'd20, 6'd63});
         drain();
         if (t == 79) check("clamp_241", {24'd0, clamp_cnt}, 32'd241);
      end
      check("clamp_saturated", {24'd0, clamp_cnt}, 32'd255);
      repeat (3) tick();
      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/neuron_activation_stage.md
Name: neuron_activation_stage

Overview:
- Downstream of NEURON. Consumes one triple of neuron results (Out, Out1, Out2) in the team's 12-bit float format: 1 sign, 5 exponent, 6 mantissa.
- Applies a clamped ReLU to each result and emits the three results one per handshake on a single output channel, feeding the next layer's input sequencer.
- Holding register, 4-state FSM, valid/ready handshakes on both sides, saturating clamp counter.

Parameters:
EXP_W, 5, exponent width
MAN_W, 6, mantissa width
MAX_EXP, 20, largest exponent passed unclamped
LEAKY_SHIFT, 2, exponent decrement for negative inputs (LEAKY_RELU_EN only)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
InValid  in  1  triple present on SignIn*/ExponentIn*/MantissaIn*
InReady  out  1  stage can accept a triple
SignIn0/1/2  in  1 each  signs of Out/Out1/Out2
ExponentIn0/1/2  in  EXP_W each  exponents
MantissaIn0/1/2  in  MAN_W each  mantissas
OutValid  out  1  activated result present
OutReady  in  1  consumer accepts result
SignOut  out  1  activated sign
ExponentOut  out  EXP_W  activated exponent
MantissaOut  out  MAN_W  activated mantissa
OutIndex  out  2  0/1/2 = which triple element
OutLast  out  1  high with OutIndex==2
ClampCount  out  8  saturating count of clamped results

Behaviour:
- One clock, Clock. Reset is synchronous and active-high, named Reset. It is sampled only on the rising edge of Clock and overrides everything.
- Reset values:
  - state IDLE, InReady=1, OutValid=0
  - SignOut=0, ExponentOut=0, MantissaOut=0
  - OutIndex=0, OutLast=0, ClampCount=0
  - holding register cleared
- FSM states: IDLE, EMIT0, EMIT1, EMIT2.
  - IDLE: InReady=1. InValid&&InReady captures all three operands into the holding register, then go to EMIT0.
  - EMITn: InReady=0, OutValid=1. The output registers hold act(operand n), OutIndex=n, OutLast=(n==2).
  - OutValid&&OutReady in EMITn: EMIT0 goes to EMIT1, EMIT1 goes to EMIT2, EMIT2 goes to IDLE.
  - Without OutReady, state and all outputs hold stable.
- Latency: capture edge, then OutValid=1 in the following cycle. Minimum 4 cycles per triple; there is no IDLE bypass.
- InValid is ignored outside IDLE. Input values may change freely after capture.
- Output data are registered and loaded on entry to each EMIT state. There is no combinational path from inputs to outputs.
- act(s,e,m), evaluated in this order:
  - e==0 && m==0 (zero, either sign) → (0,0,0).
  - s==1 (negative) → (0,0,0).
  - s==0 && e>MAX_EXP → clamp to (0, MAX_EXP, all ones). ClampCount increments once, on the OutReady acceptance of that element. It saturates at 255.
  - otherwise pass (s,e,m) unchanged.
- Reset mid-emission: the pending triple is discarded and the block returns to IDLE next cycle. The consumer never sees the remaining elements.
- OutReady held high continuously: one result per cycle, so EMIT0..EMIT2 take 3 cycles, then IDLE takes 1.

Optional Feature:
- Macro: LEAKY_RELU_EN.
- Defined: a nonzero negative input maps to (1, e-LEAKY_SHIFT, m), i.e. value scaled by 2^-LEAKY_SHIFT. If e<=LEAKY_SHIFT it underflows to (0,0,0). Negative inputs never clamp.
- Undefined: every negative input maps to (0,0,0). The LEAKY_SHIFT parameter is unused.

Test Plan:
- Reset, then capture triple (1,12,56),(0,12,7),(0,12,14) with OutReady=1:
  - first OutValid is the cycle after capture
  - outputs (0,0,0) idx0; (0,12,7) idx1; (0,12,14) idx2 with OutLast=1
  - InReady returns 1 the cycle after idx2 accept
  - ClampCount=0
- Triple (0,22,5),(0,20,9),(0,0,0):
  - outputs (0,20,63) with ClampCount→1; (0,20,9) unclamped; (0,0,0)
- Backpressure: hold OutReady=0 for 5 cycles in EMIT1:
  - OutValid stays 1 and all output fields stable
  - InValid pulses are ignored and InReady stays 0
  - release gives exactly one idx1 accept, then idx2
- Reset asserted while in EMIT1:
  - next cycle all outputs at reset values and InReady=1
  - a new triple is captured normally afterwards
- Clamp saturation: 90 triples of three clamping values (270 clamps):
  - ClampCount reaches 255 and holds
- LEAKY_RELU_EN defined:
  - (1,12,56) → (1,10,56)
  - (1,2,40) → (0,0,0)
  - (1,0,0) → (0,0,0)
  - positive path identical to the first scenario
